mxv_tx_scheduler: RTL and testbench

//  Shares the single UART TX serializer between N_REQ frame producers: MxV result sender, command ack, error report.

---
 rtl/mxv_pkg.sv | 24 ++
 rtl/mxv_rr_arbiter.sv | 38 +++
 rtl/mxv_tx_scheduler.sv | 159 +++++++++++++++
 tb/tb_mxv_tx_scheduler.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxv_pkg.sv
// Shared types and constants for the MxV UART framing path.
//   sched_state_t : TX scheduler FSM states
//   frame_phase_t : which byte of the frame the scheduler is emitting
//   FRAME_HDR     : first byte of every frame
package mxv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SEND,
        WAIT_TX,
        DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_LEN,
        PH_DATA,
        PH_CHK
    } frame_phase_t;

    localparam logic [7:0] FRAME_HDR = 8'hFE;

endpackage

// File: rtl/mxv_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request strictly after last_gnt (wrapping), so the
// previous winner is chosen again only when it is the sole requester.
//   req      in  N_REQ   request vector
//   last_gnt in  IDX_W   index of the previously served requester
//   gnt_c    out N_REQ   one-hot winner (all zero when no request)
//   idx_c    out IDX_W   winner index
//   any_c    out 1       at least one request present
module mxv_rr_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_gnt,
    output logic [N_REQ-1:0]         gnt_c,
    output logic [$clog2(N_REQ)-1:0] idx_c,
    output logic                     any_c
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // Scan offsets 1..N_REQ from the last winner; first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((32'(last_gnt) + off) % N_REQ);
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                gnt_c[cand] = 1'b1;
                idx_c       = cand;
            end
        end
    end

endmodule

// File: rtl/mxv_tx_scheduler.sv
// Shares one UART TX serializer between N_REQ frame producers.
// Each granted frame goes out as HDR, LEN, payload bytes, CHK where
// CHK = len XOR all payload bytes. Arbitration is round-robin per frame.
//   clk, rst    clock, asynchronous active-low reset
//   req_i       level request per requester, held until done_o
//   len_i       payload length per requester, sampled at grant
//   byte_i      current payload byte per requester
//   gnt_o       one-hot grant, high for the whole frame
//   rd_o        pulse: payload byte consumed
//   done_o      pulse: frame fully transmitted
//   tx_start_o  pulse: load tx_data_o into the UART
//   tx_data_o   byte to transmit, held between starts
//   tx_busy_i   UART busy
//   tx_done_i   pulse: UART finished a byte
//   busy_o      scheduler not idle
module mxv_tx_scheduler
    import mxv_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*LEN_W-1:0]  len_i,
    input  logic [N_REQ*DATA_W-1:0] byte_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        rd_o,
    output logic [N_REQ-1:0]        done_o,
    output logic                    tx_start_o,
    output logic [DATA_W-1:0]       tx_data_o,
    input  logic                    tx_busy_i,
    input  logic                    tx_done_i,
    output logic                    busy_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    sched_state_t       state;
    frame_phase_t       phase;
    logic [IDX_W-1:0]   idx;
    logic [N_REQ-1:0]   sel;
    logic [IDX_W-1:0]   last_gnt;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   cnt;
    logic [DATA_W-1:0]  chk;

    logic [N_REQ-1:0]   arb_gnt_c;
    logic [IDX_W-1:0]   arb_idx_c;
    logic               arb_any_c;
    logic [DATA_W-1:0]  cur_byte_c;
    logic [LEN_W-1:0]   cur_len_c;

    mxv_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req      (req_i),
        .last_gnt (last_gnt),
        .gnt_c    (arb_gnt_c),
        .idx_c    (arb_idx_c),
        .any_c    (arb_any_c)
    );

    // Payload byte and length of the latched requester.
    assign cur_byte_c = byte_i[32'(idx)*DATA_W +: DATA_W];
    assign cur_len_c  = len_i[32'(idx)*LEN_W +: LEN_W];

    // Frame FSM; pulse outputs default low each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= PH_HDR;
            idx        <= '0;
            sel        <= '0;
            last_gnt   <= IDX_W'(N_REQ - 1);
            len        <= '0;
            cnt        <= '0;
            chk        <= '0;
            gnt_o      <= '0;
            rd_o       <= '0;
            done_o     <= '0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            tx_start_o <= 1'b0;
            rd_o       <= '0;
            done_o     <= '0;
            case (state)
                IDLE: begin
                    busy_o <= arb_any_c;
                    if (arb_any_c) begin
                        idx   <= arb_idx_c;
                        sel   <= arb_gnt_c;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_o <= sel;
                    len   <= cur_len_c;
                    cnt   <= '0;
                    chk   <= DATA_W'(cur_len_c);
                    phase <= PH_HDR;
                    state <= SEND;
                end
                SEND: begin
                    if (!tx_busy_i) begin
                        tx_start_o <= 1'b1;
                        state      <= WAIT_TX;
                        case (phase)
                            PH_HDR:  tx_data_o <= DATA_W'(FRAME_HDR);
                            PH_LEN:  tx_data_o <= DATA_W'(len);
                            PH_DATA: begin
                                tx_data_o <= cur_byte_c;
                                rd_o      <= sel;
                                chk       <= chk ^ cur_byte_c;
                            end
                            default: tx_data_o <= chk;
                        endcase
                    end
                end
                WAIT_TX: begin
                    if (tx_done_i) begin
                        state <= SEND;
                        case (phase)
                            PH_HDR: phase <= PH_LEN;
                            PH_LEN: phase <= (len != '0) ? PH_DATA : PH_CHK;
                            PH_DATA: begin
                                cnt <= cnt + LEN_W'(1);
                                if (cnt == len - LEN_W'(1)) begin
                                    phase <= PH_CHK;
                                end
                            end
                            default: begin
                                // done_o is high during the DONE cycle so the
                                // requester can drop req_i before IDLE samples.
                                done_o <= sel;
                                state  <= DONE;
                            end
                        endcase
                    end
                end
                DONE: begin
                    gnt_o    <= '0;
                    last_gnt <= idx;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxv_tx_scheduler.sv
// Self-checking bench for mxv_tx_scheduler with a UART model
// (busy 10 cycles after each start, then a done pulse) and a frame-level
// reference model for byte streams and round-robin grant order.
module tb_mxv_tx_scheduler;

    localparam int unsigned N  = 3;
    localparam int unsigned LW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N*LW-1:0] len_i;
    logic [N*8-1:0] byte_i;
    logic [N-1:0]   gnt_o, rd_o, done_o;
    logic           tx_start_o;
    logic [7:0]     tx_data_o;
    logic           tx_busy_i, tx_done_i, busy_o;

    logic force_busy = 1'b0;
    logic stray_done = 1'b0;
    logic uart_busy  = 1'b0;
    logic uart_done  = 1'b0;
    int   uart_cnt   = 0;

    logic [7:0]    pay [N][32];
    logic [LW-1:0] lens [N];
    int ptr [N];
    int rd_cnt [N];
    int done_cnt [N];
    int cyc = 0;

    logic [7:0] tx_log [$];
    int         start_cyc [$];
    int         gnt_log [$];
    int         gnt_cyc [$];
    logic [N-1:0] gnt_prev = '0;
    int onehot_err = 0;
    int proto_err  = 0;

    logic [7:0] exp_q [$];
    int model_last = N - 1;
    int checks = 0;
    int errors = 0;

    assign tx_busy_i = uart_busy | force_busy;
    assign tx_done_i = uart_done | stray_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            byte_i[i*8 +: 8]  = (ptr[i] < 32) ? pay[i][ptr[i]] : 8'h00;
            len_i[i*LW +: LW] = lens[i];
        end
    end

    mxv_tx_scheduler #(.N_REQ(N), .DATA_W(8), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .len_i      (len_i),
        .byte_i     (byte_i),
        .gnt_o      (gnt_o),
        .rd_o       (rd_o),
        .done_o     (done_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_busy_i  (tx_busy_i),
        .tx_done_i  (tx_done_i),
        .busy_o     (busy_o)
    );

    // UART model, requester byte pointers and event logs, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            uart_cnt  = 0;
            uart_busy = 1'b0;
            uart_done = 1'b0;
            for (int i = 0; i < N; i++) ptr[i] = 0;
            gnt_prev = '0;
        end else begin
            uart_done = 1'b0;
            if (tx_start_o) begin
                tx_log.push_back(tx_data_o);
                start_cyc.push_back(cyc);
                if (tx_busy_i) proto_err++;
                uart_busy = 1'b1;
                uart_cnt  = 10;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    uart_busy = 1'b0;
                    uart_done = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rd_o[i]) begin
                    ptr[i]++;
                    rd_cnt[i]++;
                end
                if (done_o[i]) begin
                    done_cnt[i]++;
                    ptr[i] = 0;
                end
            end
            if (gnt_o != '0 && gnt_prev == '0) begin
                for (int i = 0; i < N; i++) if (gnt_o[i]) gnt_log.push_back(i);
                gnt_cyc.push_back(cyc);
            end
            gnt_prev = gnt_o;
            if ($countones(gnt_o) > 1 || $countones(rd_o) > 1 || $countones(done_o) > 1)
                onehot_err++;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rd_cnt[i] = 0;
            done_cnt[i] = 0;
            lens[i] = '0;
            for (int b = 0; b < 32; b++) pay[i][b] = 8'h00;
        end
    end

    // Watchdog: never hang.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic int sum_done();
        int s = 0;
        for (int i = 0; i < N; i++) s += done_cnt[i];
        return s;
    endfunction

    // Reference: first pending requester after 'last', wrapping.
    function automatic int next_winner(input logic [N-1:0] pend, input int last);
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Reference frame: FE, len, payload, len ^ payload.
    task automatic add_frame(input int r);
        logic [7:0] x;
        x = 8'(lens[r]);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'(lens[r]));
        for (int b = 0; b < int'(lens[r]); b++) begin
            exp_q.push_back(pay[r][b]);
            x = x ^ pay[r][b];
        end
        exp_q.push_back(x);
    endtask

    // Wait for n done pulses; requesters drop req_i when they see done_o.
    task automatic wait_frames(input int n, input int budget, output bit ok);
        int base;
        base = sum_done();
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            req_i = req_i & ~done_o;
            if (sum_done() - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt_o); end
        checks++; if (rd_o !== '0) begin errors++; $display("FAIL reset_rd: got %b expected 000", rd_o); end
        checks++; if (done_o !== '0) begin errors++; $display("FAIL reset_done: got %b expected 000", done_o); end
        checks++; if (tx_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", tx_start_o); end
        checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", tx_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst = 1'b1;
        repeat (3) step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_o); end
        model_last = N - 1;
    endtask

    task automatic test_single_frame();
        int logb, gb, rb, db, rc;
        bit ok;
        lens[0] = 5'd2; pay[0][0] = 8'h11; pay[0][1] = 8'h22;
        exp_q.delete(); add_frame(0);
        logb = tx_log.size(); gb = gnt_log.size(); rb = rd_cnt[0]; db = done_cnt[0];
        rc = cyc;
        req_i[0] = 1'b1;
        wait_frames(1, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no done expected done"); end
        checks++;
        if (gnt_cyc.size() <= gb || gnt_cyc[gb] != rc + 2) begin
            errors++; $display("FAIL single_gnt_latency: got %0d expected %0d", (gnt_cyc.size() > gb) ? gnt_cyc[gb] - rc : -1, 2);
        end
        checks++;
        if (start_cyc.size() <= logb || gnt_cyc.size() <= gb || start_cyc[logb] < gnt_cyc[gb] + 1) begin
            errors++; $display("FAIL single_start_latency: got start before cycle after grant expected later");
        end
        checks++;
        if (tx_log.size() - logb != exp_q.size()) begin
            errors++; $display("FAIL single_len: got %0d expected %0d", tx_log.size() - logb, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (tx_log[logb+k] !== exp_q[k]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", k, tx_log[logb+k], exp_q[k]); end
            end
        end
        checks++; if (rd_cnt[0] - rb != 2) begin errors++; $display("FAIL single_rd: got %0d expected 2", rd_cnt[0] - rb); end
        checks++; if (done_cnt[0] - db != 1) begin errors++; $display("FAIL single_done: got %0d expected 1", done_cnt[0] - db); end
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL single_gnt_clear: got %b expected 000", gnt_o); end
        model_last = 0;
    endtask

    task automatic test_len_zero();
        int logb, rb, db;
        bit ok;
        lens[1] = '0;
        exp_q.delete(); add_frame(1);
        logb = tx_log.size(); rb = rd_cnt[1]; db = done_cnt[1];
        req_i[1] = 1'b1;
        wait_frames(1, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL len0_timeout: got no done expected done"); end
        checks++;
        if (tx_log.size() - logb != exp_q.size()) begin
            errors++; $display("FAIL len0_len: got %0d expected %0d", tx_log.size() - logb, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (tx_log[logb+k] !== exp_q[k]) begin errors++; $display("FAIL len0_byte%0d: got %h expected %h", k, tx_log[logb+k], exp_q[k]); end
            end
        end
        checks++; if (rd_cnt[1] != rb) begin errors++; $display("FAIL len0_rd: got %0d expected 0", rd_cnt[1] - rb); end
        checks++; if (done_cnt[1] - db != 1) begin errors++; $display("FAIL len0_done: got %0d expected 1", done_cnt[1] - db); end
        model_last = 1;
    endtask

    // Raise a set of requests together and compare grant order and TX stream.
    task automatic run_group(input logic [N-1:0] mask, input string tag);
        int order [$];
        logic [N-1:0] pend;
        int last, w, logb, gb;
        bit ok;
        pend = mask; last = model_last;
        while (pend != '0) begin
            w = next_winner(pend, last);
            order.push_back(w);
            pend[w] = 1'b0;
            last = w;
        end
        exp_q.delete();
        foreach (order[k]) add_frame(order[k]);
        logb = tx_log.size(); gb = gnt_log.size();
        req_i = mask;
        wait_frames(order.size(), 6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: got no done expected %0d frames", tag, order.size()); end
        checks++;
        if (gnt_log.size() - gb != order.size()) begin
            errors++; $display("FAIL %s_grants: got %0d expected %0d", tag, gnt_log.size() - gb, order.size());
        end else begin
            foreach (order[k]) begin
                checks++;
                if (gnt_log[gb+k] != order[k]) begin errors++; $display("FAIL %s_order%0d: got %0d expected %0d", tag, k, gnt_log[gb+k], order[k]); end
            end
        end
        checks++;
        if (tx_log.size() - logb != exp_q.size()) begin
            errors++; $display("FAIL %s_len: got %0d expected %0d", tag, tx_log.size() - logb, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (tx_log[logb+k] !== exp_q[k]) begin errors++; $display("FAIL %s_byte%0d: got %h expected %h", tag, k, tx_log[logb+k], exp_q[k]); end
            end
        end
        model_last = last;
    endtask

    task automatic test_round_robin();
        rst = 1'b0; repeat (2) step(); rst = 1'b1; step();
        model_last = N - 1;
        for (int i = 0; i < N; i++) begin
            lens[i] = 5'd1;
            pay[i][0] = 8'($urandom);
        end
        run_group(3'b111, "rr_all");
        run_group(3'b101, "rr_02");
    endtask

    task automatic test_busy_hold();
        int logb, r;
        bit ok;
        lens[0] = 5'd2; pay[0][0] = 8'($urandom); pay[0][1] = 8'($urandom);
        exp_q.delete(); add_frame(0);
        logb = tx_log.size();
        force_busy = 1'b1;
        req_i[0] = 1'b1;
        repeat (20) step();
        checks++; if (tx_log.size() != logb) begin errors++; $display("FAIL busy_nostart: got %0d starts expected 0", tx_log.size() - logb); end
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL busy_gnt: got %b expected 001", gnt_o); end
        force_busy = 1'b0;
        r = cyc;
        wait_frames(1, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: got no done expected done"); end
        checks++;
        if (start_cyc.size() <= logb || start_cyc[logb] != r + 1) begin
            errors++; $display("FAIL busy_start_cycle: got %0d expected %0d", (start_cyc.size() > logb) ? start_cyc[logb] : -1, r + 1);
        end
        checks++;
        if (tx_log.size() - logb != exp_q.size()) begin
            errors++; $display("FAIL busy_len: got %0d expected %0d", tx_log.size() - logb, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (tx_log[logb+k] !== exp_q[k]) begin errors++; $display("FAIL busy_byte%0d: got %h expected %h", k, tx_log[logb+k], exp_q[k]); end
            end
        end
        model_last = 0;
    endtask

    task automatic test_drop_and_reset();
        int logb, db, rb, k;
        bit ok;
        // Request dropped after the LEN byte: frame still completes.
        lens[0] = 5'd3;
        for (int b = 0; b < 3; b++) pay[0][b] = 8'($urandom);
        exp_q.delete(); add_frame(0);
        logb = tx_log.size(); db = done_cnt[0];
        req_i[0] = 1'b1;
        k = 0;
        while (tx_log.size() < logb + 2 && k < 500) begin step(); k++; end
        req_i[0] = 1'b0;
        wait_frames(1, 2000, ok);
        checks++; if (done_cnt[0] - db != 1) begin errors++; $display("FAIL drop_done: got %0d expected 1", done_cnt[0] - db); end
        checks++;
        if (tx_log.size() - logb != exp_q.size()) begin
            errors++; $display("FAIL drop_len: got %0d expected %0d", tx_log.size() - logb, exp_q.size());
        end else begin
            for (int j = 0; j < exp_q.size(); j++) begin
                checks++;
                if (tx_log[logb+j] !== exp_q[j]) begin errors++; $display("FAIL drop_byte%0d: got %h expected %h", j, tx_log[logb+j], exp_q[j]); end
            end
        end
        model_last = 0;

        // Reset mid-payload aborts at once without done_o.
        lens[1] = 5'd8;
        for (int b = 0; b < 8; b++) pay[1][b] = 8'($urandom);
        rb = rd_cnt[1]; db = done_cnt[1];
        req_i[1] = 1'b1;
        k = 0;
        while (rd_cnt[1] - rb < 2 && k < 500) begin step(); k++; end
        checks++; if (rd_cnt[1] - rb < 2) begin errors++; $display("FAIL abort_reach: got %0d reads expected 2", rd_cnt[1] - rb); end
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt_o, rd_o, done_o, tx_start_o, tx_data_o, busy_o} !== '0) begin
            errors++; $display("FAIL abort_outputs: got gnt=%b rd=%b done=%b start=%b data=%h busy=%b expected all 0",
                               gnt_o, rd_o, done_o, tx_start_o, tx_data_o, busy_o);
        end
        req_i = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        checks++; if (done_cnt[1] != db) begin errors++; $display("FAIL abort_nodone: got %0d expected 0", done_cnt[1] - db); end
        lens[2] = 5'($urandom_range(1, 3));
        for (int b = 0; b < 3; b++) pay[2][b] = 8'($urandom);
        exp_q.delete(); add_frame(2);
        logb = tx_log.size();
        req_i[2] = 1'b1;
        k = 0;
        while (gnt_o == '0 && k < 20) begin step(); k++; end
        checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL abort_regrant: got %b expected 100", gnt_o); end
        wait_frames(1, 2000, ok);
        checks++;
        if (tx_log.size() - logb != exp_q.size()) begin
            errors++; $display("FAIL abort_frame_len: got %0d expected %0d", tx_log.size() - logb, exp_q.size());
        end else begin
            for (int j = 0; j < exp_q.size(); j++) begin
                checks++;
                if (tx_log[logb+j] !== exp_q[j]) begin errors++; $display("FAIL abort_byte%0d: got %h expected %h", j, tx_log[logb+j], exp_q[j]); end
            end
        end
        model_last = 2;
    endtask

    task automatic test_long_frame();
        int logb;
        bit ok;
        lens[0] = 5'd31;
        for (int b = 0; b < 31; b++) pay[0][b] = 8'(b);
        exp_q.delete(); add_frame(0);
        logb = tx_log.size();
        req_i[0] = 1'b1;
        wait_frames(1, 3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL long_timeout: got no done expected done"); end
        checks++;
        if (tx_log.size() - logb != exp_q.size()) begin
            errors++; $display("FAIL long_len: got %0d expected %0d", tx_log.size() - logb, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (tx_log[logb+k] !== exp_q[k]) begin errors++; $display("FAIL long_byte%0d: got %h expected %h", k, tx_log[logb+k], exp_q[k]); end
            end
        end
        model_last = 0;
        // Stray tx_done_i while idle must not start anything.
        logb = tx_log.size();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        repeat (5) step();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stray_busy: got %b expected 0", busy_o); end
        checks++; if (tx_log.size() != logb) begin errors++; $display("FAIL stray_tx: got %0d starts expected 0", tx_log.size() - logb); end
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL stray_gnt: got %b expected 000", gnt_o); end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        for (int it = 0; it < 6; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                lens[i] = 5'($urandom_range(0, 6));
                for (int b = 0; b < 6; b++) pay[i][b] = 8'($urandom);
            end
            run_group(mask, "rand");
        end
    endtask

    task automatic test_invariants();
        checks++; if (onehot_err != 0) begin errors++; $display("FAIL onehot: got %0d violations expected 0", onehot_err); end
        checks++; if (proto_err != 0) begin errors++; $display("FAIL start_while_busy: got %0d expected 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_len_zero();
        test_round_robin();
        test_busy_hold();
        test_drop_and_reset();
        test_long_frame();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
